// File: rtl/wb_stage.sv
// wb_stage: writeback stage, owner of the single register-file write port.
//   Arbitrates the port between in-order MEM results and out-of-order FPU
//   completions. FPU results that cannot be written immediately are held in
//   a small FIFO. Also keeps a retire counter and detects halt.
// Ports:
//   clk, rst                    clock (rising edge); async active-low reset
//   Z_in/alu_in/mem_in          MEM-stage destination, ALU result, load data
//   cntrl_w_in                  [0]=load [1]=store [2]=ALU write [3]=halt
//   stall_in                    1 = MEM inputs are a bubble
//   fpu_valid/fpu_Z/fpu_data    FPU completion
//   fpu_stall_out               FIFO full, so the FPU must hold its result
//   rf_we/rf_waddr/rf_wdata     registered register-file write port
//   retire_cnt, halted          retired-instruction count, halt status
//   overflow                    sticky: FPU push was attempted while full
module wb_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 4,
  parameter int FQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Z_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] mem_in,
  input  logic [3:0]        cntrl_w_in,
  input  logic              stall_in,
  input  logic              fpu_valid,
  input  logic [REG_AW-1:0] fpu_Z,
  input  logic [DATA_W-1:0] fpu_data,
  output logic              fpu_stall_out,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [31:0]       retire_cnt,
  output logic              halted,
  output logic              overflow
);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam logic [PW:0] FULL_CNT = FQ_DEPTH[PW:0];

  logic [FQ_DEPTH-1:0][REG_AW-1:0] fq_z_q, fq_z_d;
  logic [FQ_DEPTH-1:0][DATA_W-1:0] fq_d_q, fq_d_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [31:0]       retire_q, retire_d;
  logic              halted_q, halted_d;
  logic              hpend_q, hpend_d;
  logic              ovf_q, ovf_d;

  logic mem_valid, mem_wr, fq_ne, fq_full, pop, bypass, push_req, push, fpu_wr;
  logic [REG_AW-1:0] sel_addr;

  always_comb begin
    mem_valid = !stall_in && (cntrl_w_in != 4'd0) && !halted_q;
    mem_wr    = mem_valid && (cntrl_w_in[0] || cntrl_w_in[2]);
    fq_ne     = (cnt_q != '0);
    fq_full   = (cnt_q == FULL_CNT);
    pop       = !mem_wr && fq_ne;
    // Bypass only with an empty FIFO so FPU results stay in order.
    bypass    = !mem_wr && !fq_ne && fpu_valid;
    push_req  = fpu_valid && !bypass;
    push      = push_req && !fq_full;
    fpu_wr    = pop || bypass;

    fq_z_d  = fq_z_q;
    fq_d_d  = fq_d_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    if (push) begin
      fq_z_d[wptr_q] = fpu_Z;
      fq_d_d[wptr_q] = fpu_data;
      wptr_d         = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    sel_addr = '0;
    wdata_d  = '0;
    if (mem_wr) begin
      sel_addr = Z_in;
      wdata_d  = cntrl_w_in[0] ? mem_in : alu_in;
    end else if (pop) begin
      sel_addr = fq_z_q[rptr_q];
      wdata_d  = fq_d_q[rptr_q];
    end else if (bypass) begin
      sel_addr = fpu_Z;
      wdata_d  = fpu_data;
    end
    // Register 0 is hardwired: the slot is consumed and retired, never written.
    we_d    = (mem_wr || fpu_wr) && (sel_addr != '0);
    waddr_d = sel_addr;

    retire_d = retire_q + {31'd0, mem_valid} + {31'd0, fpu_wr};
    ovf_d    = ovf_q || (push_req && fq_full);
    hpend_d  = hpend_q || (mem_valid && cntrl_w_in[3]);
    halted_d = halted_q || (hpend_q && !fq_ne && !fpu_valid);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fq_z_q   <= '0;
      fq_d_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      retire_q <= '0;
      halted_q <= 1'b0;
      hpend_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      fq_z_q   <= fq_z_d;
      fq_d_q   <= fq_d_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      retire_q <= retire_d;
      halted_q <= halted_d;
      hpend_q  <= hpend_d;
      ovf_q    <= ovf_d;
    end
  end

  assign fpu_stall_out = fq_full;
  assign rf_we         = we_q;
  assign rf_waddr      = waddr_q;
  assign rf_wdata      = wdata_q;
  assign retire_cnt    = retire_q;
  assign halted        = halted_q;
  assign overflow      = ovf_q;
endmodule
